// File: rtl/stream_ctrl_pkg.sv
// Shared definitions for the stream flow controller: state encoding,
// internal counter widths and the default event-counter width.
package stream_ctrl_pkg;

    localparam int unsigned STATE_W       = 3;
    localparam int unsigned DEF_CNT_WIDTH = 16;

    // Internal counter widths cover the full legal parameter ranges
    localparam int unsigned SETTLE_W = 8;   // SETTLE_CYCLES 1..255
    localparam int unsigned PRIME_W  = 10;  // PRIME_LEVEL   1..1023
    localparam int unsigned UNF_W    = 8;   // UNF_LIMIT     1..255

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_PRIME  = 3'd2,
        ST_RUN    = 3'd3
    } state_e;

endpackage

// File: rtl/stream_flow_ctrl_sat_counter.sv
// Saturating up-counter: synchronous reset/clear, increments on i_inc,
// holds at all-ones instead of wrapping.
//   clk      : clock
//   rst      : synchronous active-high reset
//   i_clr    : synchronous clear
//   i_inc    : increment request
//   o_count  : current count
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == {WIDTH{1'b1}});

    // Count register
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_at_max) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/stream_flow_ctrl.sv
// Sequencer for the ADC -> in-FIFO -> Costas -> out-FIFO -> DAC stream.
// Waits for the in-FIFO read side to leave reset, primes the out-FIFO,
// then enables DAC playout; re-primes after a sustained underflow and
// counts overflow/underflow events for debug.
//   clk, rst    : processing clock, synchronous active-high reset
//   enable      : run request, low forces IDLE
//   in_empty    : in-FIFO empty      in_rd_busy : in-FIFO rd_rst_busy
//   in_full     : in-FIFO full (asynchronous to clk)
//   out_full    : out-FIFO full      out_empty  : out-FIFO empty
//   dsp_en      : in-FIFO rd_en / out-FIFO wr_en / Costas enable
//   out_rd_en   : out-FIFO rd_en toward the DAC
//   running     : high in RUN        state      : encoded state
//   ovf_cnt     : in-FIFO overflow events (saturating)
//   unf_cnt     : out-FIFO underflow cycles (saturating)
module stream_flow_ctrl
    import stream_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned PRIME_LEVEL   = 64,
    parameter int unsigned UNF_LIMIT     = 8,
    parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 in_empty,
    input  logic                 in_rd_busy,
    input  logic                 in_full,
    input  logic                 out_full,
    input  logic                 out_empty,
    output logic                 dsp_en,
    output logic                 out_rd_en,
    output logic                 running,
    output logic [STATE_W-1:0]   state,
    output logic [CNT_WIDTH-1:0] ovf_cnt,
    output logic [CNT_WIDTH-1:0] unf_cnt
);

    state_e              r_state;
    logic [SETTLE_W-1:0] r_settle_cnt;
    logic [PRIME_W-1:0]  r_prime_cnt;
    logic [UNF_W-1:0]    r_unf_run;
    logic                r_full_sync1;
    logic                r_full_sync2;
    logic                r_full_sync3;

    logic                w_dsp_en;
    logic [SETTLE_W-1:0] w_settle_nxt;
    logic [PRIME_W-1:0]  w_prime_nxt;
    logic [UNF_W-1:0]    w_unf_nxt;
    logic                w_settle_done;
    logic                w_prime_done;
    logic                w_unf_limit;
    logic                w_ovf_inc;
    logic                w_unf_inc;

    // FIFO handshakes act in the same cycle as the flags
    assign w_dsp_en = ((r_state == ST_PRIME) || (r_state == ST_RUN)) &&
                      !in_empty && !out_full && !in_rd_busy;

    assign w_settle_nxt  = r_settle_cnt + SETTLE_W'(1);
    assign w_prime_nxt   = r_prime_cnt + PRIME_W'(1);
    assign w_unf_nxt     = r_unf_run + UNF_W'(1);

    // Transitions fire on the cycle whose increment reaches the target
    assign w_settle_done = (w_settle_nxt == SETTLE_W'(SETTLE_CYCLES));
    assign w_prime_done  = (w_prime_nxt == PRIME_W'(PRIME_LEVEL));
    assign w_unf_limit   = (w_unf_nxt == UNF_W'(UNF_LIMIT));

    // Rising edge of the synchronised full flag
    assign w_ovf_inc = r_full_sync2 && !r_full_sync3;
    assign w_unf_inc = (r_state == ST_RUN) && out_empty;

    // in_full crosses from the write clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full_sync1 <= 1'b0;
            r_full_sync2 <= 1'b0;
            r_full_sync3 <= 1'b0;
        end else begin
            r_full_sync1 <= in_full;
            r_full_sync2 <= r_full_sync1;
            r_full_sync3 <= r_full_sync2;
        end
    end

    // Sequencing FSM; enable=0 wins over every other exit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
            r_prime_cnt  <= '0;
            r_unf_run    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state      <= ST_SETTLE;
                        r_settle_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                    end else if (in_rd_busy) begin
                        r_settle_cnt <= '0;
                    end else if (w_settle_done) begin
                        r_state     <= ST_PRIME;
                        r_prime_cnt <= '0;
                    end else begin
                        r_settle_cnt <= w_settle_nxt;
                    end
                end
                ST_PRIME: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                    end else if (out_full) begin
                        r_state   <= ST_RUN;
                        r_unf_run <= '0;
                    end else if (w_dsp_en) begin
                        if (w_prime_done) begin
                            r_state   <= ST_RUN;
                            r_unf_run <= '0;
                        end else begin
                            r_prime_cnt <= w_prime_nxt;
                        end
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        r_state <= ST_IDLE;
                    end else if (out_empty) begin
                        if (w_unf_limit) begin
                            r_state     <= ST_PRIME;
                            r_prime_cnt <= '0;
                        end else begin
                            r_unf_run <= w_unf_nxt;
                        end
                    end else begin
                        r_unf_run <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_ovf_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_inc   (w_ovf_inc),
        .o_count (ovf_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_unf_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (1'b0),
        .i_inc   (w_unf_inc),
        .o_count (unf_cnt)
    );

    assign dsp_en    = w_dsp_en;
    assign out_rd_en = (r_state == ST_RUN) && !out_empty;
    assign running   = (r_state == ST_RUN);
    assign state     = r_state;

endmodule

// File: tb/tb_stream_flow_ctrl.sv
// Self-checking bench for stream_flow_ctrl. Inputs change on the falling
// edge, outputs are sampled on the falling edge (or #1 after a drive).
module tb_stream_flow_ctrl;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned N_VEC = 22;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, enable, in_empty, in_rd_busy, in_full, out_full, out_empty;
    logic             dsp_en, out_rd_en, running;
    logic [2:0]       state;
    logic [CNT_W-1:0] ovf_cnt, unf_cnt;
    logic             s_dsp_en, s_out_rd_en, s_running;
    logic [2:0]       s_state;
    logic [3:0]       s_ovf_cnt, s_unf_cnt;

    stream_flow_ctrl #(
        .SETTLE_CYCLES (16),
        .PRIME_LEVEL   (64),
        .UNF_LIMIT     (8),
        .CNT_WIDTH     (CNT_W)
    ) u_dut (
        .clk (clk), .rst (rst), .enable (enable),
        .in_empty (in_empty), .in_rd_busy (in_rd_busy), .in_full (in_full),
        .out_full (out_full), .out_empty (out_empty),
        .dsp_en (dsp_en), .out_rd_en (out_rd_en), .running (running),
        .state (state), .ovf_cnt (ovf_cnt), .unf_cnt (unf_cnt)
    );

    // Narrow-counter instance for saturation
    stream_flow_ctrl #(
        .SETTLE_CYCLES (16),
        .PRIME_LEVEL   (64),
        .UNF_LIMIT     (8),
        .CNT_WIDTH     (4)
    ) u_sat (
        .clk (clk), .rst (rst), .enable (enable),
        .in_empty (in_empty), .in_rd_busy (in_rd_busy), .in_full (in_full),
        .out_full (out_full), .out_empty (out_empty),
        .dsp_en (s_dsp_en), .out_rd_en (s_out_rd_en), .running (s_running),
        .state (s_state), .ovf_cnt (s_ovf_cnt), .unf_cnt (s_unf_cnt)
    );

    typedef struct packed {
        logic ie;
        logic of;
        logic oe;
        logic exp_dsp;
        logic exp_rd;
    } vec_t;

    vec_t vecs [N_VEC];
    vec_t sb_q [$];

    int  n_checks = 0;
    int  n_errors = 0;
    int  exp_ovf  = 0;
    int  exp_unf  = 0;
    bit  mon_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Handshake outputs must never contradict the FIFO flags
    always @(negedge clk) begin
        if (mon_on) begin
            n_checks++;
            if ((dsp_en && (in_empty || out_full || in_rd_busy)) || (out_rd_en && out_empty)) begin
                n_errors++;
                $display("FAIL gating_invariant: dsp_en=%0b out_rd_en=%0b in_empty=%0b out_full=%0b in_rd_busy=%0b out_empty=%0b at %0t",
                         dsp_en, out_rd_en, in_empty, out_full, in_rd_busy, out_empty, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Flag-gating vectors applied in RUN
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 6; i < int'(N_VEC); i++) begin
            logic ie, of;
            ie = 1'($urandom_range(0, 1));
            of = 1'($urandom_range(0, 1));
            vecs[i] = '{ie, of, 1'b0, ~(ie | of), 1'b1};
        end

        rst = 1'b1; enable = 1'b0; in_empty = 1'b1; in_rd_busy = 1'b0;
        in_full = 1'b0; out_full = 1'b0; out_empty = 1'b1;
        tick(4);
        check("rst_state", 32'(state), 32'd0);
        check("rst_dsp_en", 32'(dsp_en), 32'd0);
        check("rst_out_rd_en", 32'(out_rd_en), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_ovf", 32'(ovf_cnt), 32'd0);
        check("rst_unf", 32'(unf_cnt), 32'd0);

        // Startup: SETTLE for 10 busy + 16 quiet cycles
        rst = 1'b0; enable = 1'b1; in_rd_busy = 1'b1;
        mon_on = 1'b1;
        tick(1);
        check("enter_settle", 32'(state), 32'd1);
        tick(10);
        check("settle_busy", 32'(state), 32'd1);
        in_rd_busy = 1'b0;
        tick(14);
        in_empty = 1'b0;
        tick(1);
        check("settle_15", 32'(state), 32'd1);
        check("settle_no_dsp", 32'(dsp_en), 32'd0);
        tick(1);
        check("prime_entry", 32'(state), 32'd2);
        check("prime_dsp_en", 32'(dsp_en), 32'd1);

        // PRIME counts only dsp_en cycles
        tick(30);
        in_empty = 1'b1;
        tick(5);
        check("prime_gap_state", 32'(state), 32'd2);
        check("prime_gap_dsp", 32'(dsp_en), 32'd0);
        in_empty = 1'b0; out_empty = 1'b0;
        #1;
        check("prime_resume_dsp", 32'(dsp_en), 32'd1);
        check("prime_no_rd", 32'(out_rd_en), 32'd0);
        tick(33);
        check("prime_63", 32'(state), 32'd2);
        tick(1);
        check("run_state", 32'(state), 32'd3);
        check("run_running", 32'(running), 32'd1);
        check("run_out_rd_en", 32'(out_rd_en), 32'd1);

        // Table-driven flag gating through the scoreboard
        for (int i = 0; i < int'(N_VEC); i++) begin
            vec_t v;
            in_empty = vecs[i].ie; out_full = vecs[i].of; out_empty = vecs[i].oe;
            sb_q.push_back(vecs[i]);
            if (vecs[i].oe) exp_unf++;
            tick(1);
            v = sb_q.pop_front();
            check($sformatf("vec%0d_dsp_en", i), 32'(dsp_en), 32'(v.exp_dsp));
            check($sformatf("vec%0d_out_rd_en", i), 32'(out_rd_en), 32'(v.exp_rd));
            check($sformatf("vec%0d_state", i), 32'(state), 32'd3);
        end
        in_empty = 1'b0; out_full = 1'b0; out_empty = 1'b0;
        tick(1);
        check("unf_after_table", 32'(unf_cnt), 32'(exp_unf));

        // Underflow: 5-cycle burst, one good cycle, 8-cycle burst
        out_empty = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            check("unf_b1_rd", 32'(out_rd_en), 32'd0);
        end
        check("unf_b1_state", 32'(state), 32'd3);
        check("unf_b1_cnt", 32'(unf_cnt), 32'(exp_unf + 5));
        out_empty = 1'b0;
        tick(1);
        check("unf_gap_state", 32'(state), 32'd3);
        out_empty = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick(1);
            check("unf_b2_rd", 32'(out_rd_en), 32'd0);
        end
        check("unf_b2_7_state", 32'(state), 32'd3);
        tick(1);
        exp_unf += 13;
        check("unf_reprime_state", 32'(state), 32'd2);
        check("unf_total", 32'(unf_cnt), 32'(exp_unf));
        out_empty = 1'b0;

        // Early prime exit on out_full after 20 writes
        tick(20);
        check("early_prime_state", 32'(state), 32'd2);
        out_full = 1'b1;
        #1;
        check("early_full_dsp", 32'(dsp_en), 32'd0);
        tick(1);
        check("early_run_state", 32'(state), 32'd3);
        check("early_run_rd", 32'(out_rd_en), 32'd1);
        out_full = 1'b0;

        // Overflow: two 3-cycle pulses, rises 10 cycles apart
        for (int p = 0; p < 2; p++) begin
            in_full = 1'b1;
            for (int k = 1; k <= 10; k++) begin
                tick(1);
                if (k < 3) begin
                    check("ovf_latency", 32'(ovf_cnt), 32'(exp_ovf));
                end else if (k == 3) begin
                    exp_ovf++;
                    check("ovf_incr", 32'(ovf_cnt), 32'(exp_ovf));
                    in_full = 1'b0;
                end
            end
        end
        check("ovf_two", 32'(ovf_cnt), 32'd2);
        check("ovf_narrow_two", 32'(s_ovf_cnt), 32'd2);

        // Saturation of the 4-bit instance
        for (int p = 0; p < 20; p++) begin
            in_full = 1'b1;
            tick(3);
            in_full = 1'b0;
            tick(3);
        end
        tick(3);
        exp_ovf += 20;
        check("ovf_wide_count", 32'(ovf_cnt), 32'(exp_ovf));
        check("ovf_narrow_sat", 32'(s_ovf_cnt), 32'd15);

        // Abort from RUN and from PRIME; counters hold
        enable = 1'b0;
        tick(1);
        check("abort_run_state", 32'(state), 32'd0);
        check("abort_run_running", 32'(running), 32'd0);
        check("abort_run_rd", 32'(out_rd_en), 32'd0);
        check("abort_run_ovf", 32'(ovf_cnt), 32'(exp_ovf));
        check("abort_run_unf", 32'(unf_cnt), 32'(exp_unf));
        enable = 1'b1;
        tick(1);
        check("reenter_settle", 32'(state), 32'd1);
        tick(16);
        check("reenter_prime", 32'(state), 32'd2);
        tick(5);
        enable = 1'b0;
        #1;
        check("abort_prime_pre_dsp", 32'(dsp_en), 32'd1);
        tick(1);
        check("abort_prime_state", 32'(state), 32'd0);
        check("abort_prime_dsp", 32'(dsp_en), 32'd0);
        check("abort_prime_ovf", 32'(ovf_cnt), 32'(exp_ovf));
        check("abort_prime_unf", 32'(unf_cnt), 32'(exp_unf));

        // enable=0 beats PRIME completion in the same cycle
        enable = 1'b1;
        tick(17);
        tick(63);
        check("prio_prime_63", 32'(state), 32'd2);
        enable = 1'b0;
        tick(1);
        check("prio_abort_state", 32'(state), 32'd0);

        // Reset mid-RUN clears everything
        enable = 1'b1;
        tick(17);
        tick(64);
        check("rst_mid_pre_state", 32'(state), 32'd3);
        rst = 1'b1;
        tick(1);
        check("rst_mid_state", 32'(state), 32'd0);
        check("rst_mid_ovf", 32'(ovf_cnt), 32'd0);
        check("rst_mid_unf", 32'(unf_cnt), 32'd0);
        check("rst_mid_dsp", 32'(dsp_en), 32'd0);
        check("rst_mid_rd", 32'(out_rd_en), 32'd0);
        check("rst_mid_running", 32'(running), 32'd0);
        check("rst_mid_narrow", 32'({s_state, s_ovf_cnt, s_unf_cnt, s_dsp_en, s_out_rd_en, s_running}), 32'd0);
        rst = 1'b0; enable = 1'b0;
        tick(1);
        check("post_rst_idle", 32'(state), 32'd0);

        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
